dma_controller_chan_cache: RTL and testbench

Multi-channel successor to the DMA controller's single-region RAM cache: one simple-dual-port SRAM is partitioned into CHANNELS equal circular FIFO regions, each with its own pointers, full/empty flags and flush. It sits between the DMA read-master (writer) and write-master (reader) and replaces the tied-off error outputs with real per-byte parity checking. Read data is registered, with one-cycle latency.

---
 rtl/dma_cache_pkg.sv | 35 +++
 rtl/dma_cache_sdp_ram.sv | 36 +++
 rtl/dma_controller_chan_cache.sv | 133 +++++++++++++
 tb/tb_dma_controller_chan_cache.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dma_cache_pkg.sv
// Shared helpers for the channelised DMA cache.
//   clog2 / ch_width / slots / ptr_width : derived widths.
//   byte_parity : even parity of every byte of a word. The input is
//                 zero-extended to MAX_W, so callers truncate the result
//                 to WIDTH/8 bits.
package dma_cache_pkg;

  localparam int MAX_W = 1024;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction

  function automatic int ch_width(input int ch);
    return (clog2(ch) < 1) ? 1 : clog2(ch);
  endfunction

  function automatic int slots(input int depth, input int ch);
    return depth / ch;
  endfunction

  // One extra MSB distinguishes full from empty when the low bits match.
  function automatic int ptr_width(input int depth, input int ch);
    return clog2(slots(depth, ch)) + 1;
  endfunction

  function automatic logic [MAX_W/8-1:0] byte_parity(input logic [MAX_W-1:0] d);
    logic [MAX_W/8-1:0] p;
    for (int i = 0; i < MAX_W/8; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

endpackage

// File: rtl/dma_cache_sdp_ram.sv
// Generic simple-dual-port RAM: one write port, one registered read port.
//   i_clk            clock
//   i_rst            sync active-high reset of the read register only
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr     read port; o_rdata updates only on i_re, else holds
//   o_rdata          registered read data
module dma_cache_sdp_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/dma_controller_chan_cache.sv
// Multi-channel DMA cache: one SDP RAM split into CHANNELS circular FIFOs.
//   i_clock, i_reset     clock, sync active-high reset
//   i_wen/i_wchan/i_wdata/i_wpar_flip  write request (+ parity bit0 inject)
//   o_wready             !full[wchan] && !flush[wchan] (combinational)
//   i_ren/i_rchan        read request
//   o_rvalid/o_rdata/o_rchan_out/o_par_err  read return, 1 cycle after accept
//   i_flush              per-channel pointer clear
//   o_full/o_empty       registered per-channel flags
module dma_controller_chan_cache
  import dma_cache_pkg::*;
#(
  parameter  int WIDTH    = 128,
  parameter  int DEPTH    = 128,
  parameter  int CHANNELS = 4,
  parameter  int PARITY   = 1,
  localparam int CW       = ch_width(CHANNELS),
  localparam int PW       = ptr_width(DEPTH, CHANNELS)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_wen,
  input  logic [CW-1:0]       i_wchan,
  input  logic [WIDTH-1:0]    i_wdata,
  input  logic                i_wpar_flip,
  output logic                o_wready,
  input  logic                i_ren,
  input  logic [CW-1:0]       i_rchan,
  output logic                o_rvalid,
  output logic [WIDTH-1:0]    o_rdata,
  output logic [CW-1:0]       o_rchan_out,
  output logic                o_par_err,
  input  logic [CHANNELS-1:0] i_flush,
  output logic [CHANNELS-1:0] o_full,
  output logic [CHANNELS-1:0] o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int PB = (PARITY != 0) ? WIDTH/8 : 0;
  localparam int RW = WIDTH + PB;

  logic [CHANNELS-1:0][PW-1:0] r_wp, r_rp, w_wp_nx, w_rp_nx;
  logic [CHANNELS-1:0]         r_full, r_empty, w_full_nx, w_empty_nx;
  logic                        r_rvalid;
  logic [CW-1:0]               r_rchan;
  logic                        w_wacc, w_racc;
  logic [PW-2:0]               w_wlow, w_rlow;
  logic [AW-1:0]               w_waddr, w_raddr;
  logic [RW-1:0]               w_ram_wd, w_ram_rd;

  // Accept decisions use only registered flags: no full/empty look-through.
  assign o_wready = !r_full[i_wchan] && !i_flush[i_wchan];
  assign w_wacc   = i_wen && o_wready && !i_reset;
  assign w_racc   = i_ren && !r_empty[i_rchan] && !i_flush[i_rchan] && !i_reset;

  assign w_wlow  = r_wp[i_wchan][PW-2:0];
  assign w_rlow  = r_rp[i_rchan][PW-2:0];
  assign w_waddr = AW'({i_wchan, w_wlow});
  assign w_raddr = AW'({i_rchan, w_rlow});

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_wp_nx[c] = r_wp[c];
      w_rp_nx[c] = r_rp[c];
      if (i_flush[c]) begin
        w_wp_nx[c] = '0;
        w_rp_nx[c] = '0;
      end else begin
        if (w_wacc && int'(i_wchan) == c) w_wp_nx[c] = r_wp[c] + PW'(1);
        if (w_racc && int'(i_rchan) == c) w_rp_nx[c] = r_rp[c] + PW'(1);
      end
      w_empty_nx[c] = (w_wp_nx[c] == w_rp_nx[c]);
      w_full_nx[c]  = (w_wp_nx[c][PW-1] != w_rp_nx[c][PW-1]) &&
                      (w_wp_nx[c][PW-2:0] == w_rp_nx[c][PW-2:0]);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_full  <= '0;
      r_empty <= '1;
    end else begin
      r_wp    <= w_wp_nx;
      r_rp    <= w_rp_nx;
      r_full  <= w_full_nx;
      r_empty <= w_empty_nx;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rvalid <= 1'b0;
      r_rchan  <= '0;
    end else begin
      r_rvalid <= w_racc;
      if (w_racc) r_rchan <= i_rchan;
    end
  end

  // Read and write can never hit the same address in one cycle: equal low
  // bits on a non-empty channel means full, which blocks the write.
  dma_cache_sdp_ram #(.DW(RW), .AW(AW)) u_ram (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_we    (w_wacc),
    .i_waddr (w_waddr),
    .i_wdata (w_ram_wd),
    .i_re    (w_racc),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rd)
  );

  generate
    if (PARITY != 0) begin : g_par
      logic [PB-1:0] w_wpar, w_rpar_calc;
      assign w_wpar      = PB'(byte_parity(MAX_W'(i_wdata))) ^ PB'(i_wpar_flip);
      assign w_ram_wd    = {w_wpar, i_wdata};
      assign w_rpar_calc = PB'(byte_parity(MAX_W'(w_ram_rd[WIDTH-1:0])));
      assign o_par_err   = r_rvalid && (w_rpar_calc != w_ram_rd[RW-1:WIDTH]);
    end else begin : g_nopar
      assign w_ram_wd  = i_wdata;
      assign o_par_err = 1'b0;
    end
  endgenerate

  assign o_rvalid    = r_rvalid;
  assign o_rdata     = w_ram_rd[WIDTH-1:0];
  assign o_rchan_out = r_rchan;
  assign o_full      = r_full;
  assign o_empty     = r_empty;

endmodule

// File: tb/tb_dma_controller_chan_cache.sv
module tb_dma_controller_chan_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wen = 1'b0, flip = 1'b0, ren = 1'b0;
  logic [1:0]   wchan = '0, rchan = '0;
  logic [127:0] wdata = '0;
  logic [3:0]   flush = '0;

  logic         wready, rvalid, par_err;
  logic [127:0] rdata;
  logic [1:0]   rchan_out;
  logic [3:0]   full, empty;

  logic         wready0, rvalid0, par_err0;
  logic [127:0] rdata0;
  logic [1:0]   rchan_out0;
  logic [3:0]   full0, empty0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  dma_controller_chan_cache #(.WIDTH(128), .DEPTH(128), .CHANNELS(4), .PARITY(1)) dut (
    .i_clock(clk), .i_reset(rst), .i_wen(wen), .i_wchan(wchan), .i_wdata(wdata),
    .i_wpar_flip(flip), .o_wready(wready), .i_ren(ren), .i_rchan(rchan),
    .o_rvalid(rvalid), .o_rdata(rdata), .o_rchan_out(rchan_out), .o_par_err(par_err),
    .i_flush(flush), .o_full(full), .o_empty(empty));

  // Same stimulus, parity storage removed.
  dma_controller_chan_cache #(.WIDTH(128), .DEPTH(128), .CHANNELS(4), .PARITY(0)) dut_np (
    .i_clock(clk), .i_reset(rst), .i_wen(wen), .i_wchan(wchan), .i_wdata(wdata),
    .i_wpar_flip(flip), .o_wready(wready0), .i_ren(ren), .i_rchan(rchan),
    .o_rvalid(rvalid0), .o_rdata(rdata0), .o_rchan_out(rchan_out0), .o_par_err(par_err0),
    .i_flush(flush), .o_full(full0), .o_empty(empty0));

  typedef struct {
    logic w; logic [1:0] wc; logic [127:0] wd; logic fl;
    logic r; logic [1:0] rc; logic [3:0] fs;
    logic e_wrdy; logic e_rv; logic [127:0] e_rd; logic [1:0] e_rch;
    logic e_par; logic [3:0] e_full; logic [3:0] e_empty;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic drv(input logic w, input logic [1:0] wc, input logic [127:0] wd,
                     input logic fl, input logic r, input logic [1:0] rc, input logic [3:0] fs);
    @(negedge clk);
    wen = w; wchan = wc; wdata = wd; flip = fl; ren = r; rchan = rc; flush = fs;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] c, input logic [127:0] d);
    drv(1'b1, c, d, 1'b0, 1'b0, 2'd0, 4'h0); tick;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] c, input logic [127:0] d);
    drv(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, c, 4'h0); tick;
    chk({nm, "_rvalid"}, rvalid, 1'b1);
    chk({nm, "_rdata"}, rdata, d);
  endtask

  initial begin
    // {w,wc,wd,fl, r,rc,fs, e_wrdy,e_rv,e_rd,e_rch,e_par,e_full,e_empty}
    vec[0] = '{1'b1,2'd2,128'h11,1'b0, 1'b0,2'd0,4'h0, 1'b1,1'b0,128'h0, 2'd0,1'b0,4'h0,4'b1011};
    vec[1] = '{1'b1,2'd2,128'h22,1'b0, 1'b1,2'd2,4'h0, 1'b1,1'b1,128'h11,2'd2,1'b0,4'h0,4'b1011};
    vec[2] = '{1'b0,2'd0,128'h0, 1'b0, 1'b1,2'd2,4'h0, 1'b1,1'b1,128'h22,2'd2,1'b0,4'h0,4'b1111};
    vec[3] = '{1'b0,2'd0,128'h0, 1'b0, 1'b1,2'd2,4'h0, 1'b1,1'b0,128'h0, 2'd0,1'b0,4'h0,4'b1111};
    vec[4] = '{1'b1,2'd1,128'h33,1'b0, 1'b1,2'd1,4'h0, 1'b1,1'b0,128'h0, 2'd0,1'b0,4'h0,4'b1101};
    vec[5] = '{1'b0,2'd0,128'h0, 1'b0, 1'b1,2'd1,4'h0, 1'b1,1'b1,128'h33,2'd1,1'b0,4'h0,4'b1111};
    vec[6] = '{1'b1,2'd3,128'h44,1'b1, 1'b0,2'd0,4'h0, 1'b1,1'b0,128'h0, 2'd0,1'b0,4'h0,4'b0111};
    vec[7] = '{1'b0,2'd0,128'h0, 1'b0, 1'b1,2'd3,4'h0, 1'b1,1'b1,128'h44,2'd3,1'b1,4'h0,4'b1111};
    vec[8] = '{1'b1,2'd0,128'h55,1'b0, 1'b0,2'd0,4'h1, 1'b0,1'b0,128'h0, 2'd0,1'b0,4'h0,4'b1111};
    vec[9] = '{1'b0,2'd0,128'h0, 1'b0, 1'b1,2'd0,4'h0, 1'b1,1'b0,128'h0, 2'd0,1'b0,4'h0,4'b1111};

    // Reset
    tick; tick;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_empty", empty, 4'b1111);
    chk("rst_full", full, 4'h0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 128'h0);
    chk("rst_rchan", rchan_out, 2'd0);
    chk("rst_par", par_err, 1'b0);
    chk("rst_wready", wready, 1'b1);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      drv(vec[i].w, vec[i].wc, vec[i].wd, vec[i].fl, vec[i].r, vec[i].rc, vec[i].fs);
      #1 chk($sformatf("v%0d_wready", i), wready, vec[i].e_wrdy);
      tick;
      chk($sformatf("v%0d_rvalid", i), rvalid, vec[i].e_rv);
      if (vec[i].e_rv) begin
        chk($sformatf("v%0d_rdata", i), rdata, vec[i].e_rd);
        chk($sformatf("v%0d_rchan", i), rchan_out, vec[i].e_rch);
      end
      chk($sformatf("v%0d_par", i), par_err, vec[i].e_par);
      chk($sformatf("v%0d_full", i), full, vec[i].e_full);
      chk($sformatf("v%0d_empty", i), empty, vec[i].e_empty);
    end

    // Fill/drain ch2, overflow write dropped
    for (int i = 0; i < 32; i++) wr(2'd2, 128'(i));
    chk("fill_full2", full[2], 1'b1);
    chk("fill_empty2", empty[2], 1'b0);
    drv(1'b1, 2'd2, 128'd99, 1'b0, 1'b0, 2'd0, 4'h0);
    #1 chk("fill_wready_full", wready, 1'b0);
    tick;
    for (int i = 0; i < 32; i++) begin
      rd_chk($sformatf("drain%0d", i), 2'd2, 128'(i));
      chk($sformatf("drain%0d_rchan", i), rchan_out, 2'd2);
      if (i == 0) chk("drain_full_clr", full[2], 1'b0);
    end
    drv(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, 2'd2, 4'h0); tick;
    chk("drain_no99", rvalid, 1'b0);
    chk("drain_empty2", empty[2], 1'b1);

    // Isolation ch0/ch3
    for (int i = 0; i < 4; i++) begin
      wr(2'd0, 128'h100 + 128'(i));
      wr(2'd3, 128'h300 + 128'(i));
    end
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("iso0_%0d", i), 2'd0, 128'h100 + 128'(i));
      rd_chk($sformatf("iso3_%0d", i), 2'd3, 128'h300 + 128'(i));
    end

    // Pointer wrap on ch1
    for (int i = 0; i < 40; i++) begin
      wr(2'd1, 128'h500 + 128'(i));
      rd_chk($sformatf("wrap%0d", i), 2'd1, 128'h500 + 128'(i));
    end

    // Full ch0, simultaneous WEN+REN: write rejected, oldest word read
    for (int i = 0; i < 32; i++) wr(2'd0, 128'h700 + 128'(i));
    drv(1'b1, 2'd0, 128'hDEAD, 1'b0, 1'b1, 2'd0, 4'h0);
    #1 chk("simfull_wready", wready, 1'b0);
    tick;
    chk("simfull_rvalid", rvalid, 1'b1);
    chk("simfull_rdata", rdata, 128'h700);
    chk("simfull_full0", full[0], 1'b0);
    for (int i = 1; i < 32; i++) rd_chk($sformatf("simdrain%0d", i), 2'd0, 128'h700 + 128'(i));
    drv(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, 2'd0, 4'h0); tick;
    chk("simfull_nodead", rvalid, 1'b0);

    // Flush ch1 with same-cycle write; ch0/ch3 untouched
    wr(2'd0, 128'hA0);
    wr(2'd3, 128'hB0);
    for (int i = 0; i < 5; i++) wr(2'd1, 128'h900 + 128'(i));
    drv(1'b1, 2'd1, 128'h999, 1'b0, 1'b0, 2'd0, 4'b0010);
    #1 chk("flush_wready", wready, 1'b0);
    tick;
    chk("flush_empty1", empty[1], 1'b1);
    drv(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, 2'd1, 4'h0); tick;
    chk("flush_noread", rvalid, 1'b0);
    chk("flush_empty1_hold", empty[1], 1'b1);
    rd_chk("flush_ch0", 2'd0, 128'hA0);
    rd_chk("flush_ch3", 2'd3, 128'hB0);

    // Flush overrides a same-cycle read
    wr(2'd2, 128'hC0);
    drv(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, 2'd2, 4'b0100); tick;
    chk("flushrd_rvalid", rvalid, 1'b0);
    chk("flushrd_empty", empty, 4'b1111);

    // Parity
    drv(1'b1, 2'd0, {16{8'hA5}}, 1'b1, 1'b0, 2'd0, 4'h0); tick;
    drv(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, 2'd0, 4'h0); tick;
    chk("par_rvalid", rvalid, 1'b1);
    chk("par_err", par_err, 1'b1);
    chk("par_np_rvalid", rvalid0, 1'b1);
    chk("par_np_err", par_err0, 1'b0);
    wr(2'd0, {16{8'h5B}});
    drv(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, 2'd0, 4'h0); tick;
    chk("par_clean_rvalid", rvalid, 1'b1);
    chk("par_clean_rdata", rdata, {16{8'h5B}});
    chk("par_clean_err", par_err, 1'b0);

    // Reset mid-operation kills the read and the write
    wr(2'd3, 128'h77);
    @(negedge clk);
    rst = 1'b1; ren = 1'b1; rchan = 2'd3; wen = 1'b1; wchan = 2'd2; wdata = 128'h88;
    tick;
    chk("mrst_rvalid", rvalid, 1'b0);
    chk("mrst_rdata", rdata, 128'h0);
    chk("mrst_empty", empty, 4'b1111);
    chk("mrst_full", full, 4'h0);
    drv(1'b0, 2'd0, 128'h0, 1'b0, 1'b1, 2'd3, 4'h0);
    rst = 1'b0;
    tick;
    chk("mrst_noread", rvalid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
